shreg_fifo: RTL and testbench
=============================

# shreg_fifo

First-word-fall-through FIFO built on a variable-tap shift register. The writer shifts into a reset-free shift register, and the reader taps it at a position set by the current occupancy. It is the read-side counterpart to the dynamic-length shift-register tests: synth_xilinx must map the storage onto SRLC32E chains. Control state is reset; storage is never reset.

## Interface
Parameters:
- WIDTH, 1, data bits per entry (≥1)
- DEPTH, 130, entries (≥2); deliberately not a multiple of 32, to exercise SRL cascading
- AW, derived = clog2(DEPTH+1), occupancy width

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- r_n  in  1  reset; synchronous and active-low
- i_data  in  WIDTH  write data
- i_valid  in  1  writer offers i_data
- i_ready  out  1  FIFO accepts a write
- q_data  out  WIDTH  oldest entry (fall-through)
- q_valid  out  1  q_data holds a valid entry
- q_ready  in  1  reader consumes q_data
- level  out  AW  occupancy; present only with SHREG_FIFO_LEVEL_EN

## Operation
Storage:
- DEPTH×WIDTH shift register sr. No reset, no init.
- Only enable is push: sr[0] <= i_data and sr[k] <= sr[k-1].

Control:
- Registered count, 0..DEPTH.
- push = i_valid & i_ready; pop = q_valid & q_ready.
- i_ready = r_n & (count != DEPTH); q_valid = r_n & (count != 0). Both are pure functions of registers and r_n, with no combinational path from q_ready or i_valid.
- Read tap: q_data = sr[idx], where idx = count-1 saturated at 0. When empty, q_data shows sr[0] and the bench ignores it.

Count update:
- push only: count+1
- pop only: count-1
- both: count unchanged. The shift moves the next-oldest entry into sr[idx].
- neither: count held

Boundaries:
- Full: i_ready=0, so a write is refused even when a pop happens in the same cycle.
- Empty: no pop is possible. A push into an empty FIFO appears on q_data the next cycle.
- Wrap-around: none. Position is implicit in count, so there are no pointers.

Reset:
- r_n low at an edge: count <= 0. This includes reset mid-stream; in-flight data is discarded.
- While r_n is low, i_ready=0 and q_valid=0, and pushes are ignored.
- Storage keeps its stale contents, which are never exposed because q_valid=0 until a new push.

## Timing
- Reset values: count=0, q_valid=0, level=0. i_ready=0 while r_n is low and 1 on the first cycle after release.
- Write-to-read latency: 1 cycle. A push at edge n gives q_valid=1 with the pushed data from edge n on.
- Throughput: one push and one pop per cycle, sustained, with no bubbles.
- Read path: combinational mux from count to the sr tap (SRL A-address path). No other combinational paths.

## Configuration
- SHREG_FIFO_LEVEL_EN defined: output port level = count, registered, reset 0.
- Not defined: port absent and count internal only. The storage mapping is unchanged.

## Structure
- Package shreg_fifo_pkg holds:
  - the clog2 constant function
  - the AW derivation
  - a localparam for the SRL segment length (32)
- One sub-module, shreg_tap: WIDTH×DEPTH reset-free shift register with shift enable and a variable read index. This is the part that must infer SRLC32E cascades.
- Count, handshake and reset logic stay in shreg_fifo. No reset may reach shreg_tap, or SRL inference is blocked.

## Test plan
- Reset then idle: r_n=0 for 2 cycles → i_ready=0, q_valid=0. After release, i_ready=1, q_valid=0, level=0.
- Single word: push 0x1 with q_ready=0 → next cycle q_valid=1, q_data=0x1, level=1. Pulse q_ready → q_valid=0, level=0.
- Fill to DEPTH: push 0,1,0,1… for 130 cycles → i_ready=0 at level 130, and a 131st push is ignored. Draining yields the exact sequence in order.
- Full plus simultaneous pop: full, i_valid=1, q_ready=1 → only the pop occurs, level=129. The next cycle push and pop both occur and level stays 129.
- Streaming: i_valid=q_ready=1 for 500 cycles with a pseudo-random pattern → output equals input delayed 1 cycle, level constant.
- Reset mid-stream: level=40, r_n=0 for one cycle → q_valid=0 and level=0. After release, a push of 0x1 reads back 0x1 with no stale data.

Source files
------------

// File: rtl/shreg_fifo_pkg.sv
// Shared constants and helpers for the shift-register FIFO: width derivation
// and the SRL segment length the storage is expected to cascade on.
package shreg_fifo_pkg;

   localparam int SRL_SEG_LEN   = 32;
   localparam int DEFAULT_WIDTH = 1;
   localparam int DEFAULT_DEPTH = 130;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v = value - 1;
      while (v > 0) begin
         result = result + 1;
         v = v >> 1;
      end
      return result;
   endfunction

   // Occupancy must represent 0..depth inclusive, hence depth+1 states.
   function automatic int fifo_aw(input int depth);
      return clog2(depth + 1);
   endfunction

   localparam int DEFAULT_AW = fifo_aw(DEFAULT_DEPTH);

endpackage

// File: rtl/shreg_tap.sv
// Reset-free WIDTH x DEPTH shift register with shift enable and a variable
// read tap; kept free of any reset so it can map onto cascaded SRL primitives.
module shreg_tap
   import shreg_fifo_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int AW    = fifo_aw(DEPTH)
) (
   input  logic             clk,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   input  logic [AW-1:0]    idx,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] sr [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         sr[0] <= din;
         for (int k = 1; k < DEPTH; k++) begin
            sr[k] <= sr[k-1];
         end
      end
   end

   assign dout = sr[idx];

endmodule

// File: rtl/shreg_fifo.sv
// First-word-fall-through FIFO over a variable-tap shift register.
// Define SHREG_FIFO_LEVEL_EN to expose the registered occupancy on port level.
module shreg_fifo
   import shreg_fifo_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int AW    = fifo_aw(DEPTH)
) (
   input  logic             clk,
   input  logic             r_n,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_valid,
   output logic             i_ready,
   output logic [WIDTH-1:0] q_data,
   output logic             q_valid,
   input  logic             q_ready
`ifdef SHREG_FIFO_LEVEL_EN
   ,
   output logic [AW-1:0]    level
`endif
);

   localparam logic [AW-1:0] FULL = AW'(DEPTH);

   logic [AW-1:0] count;
   logic [AW-1:0] idx;
   logic          push;
   logic          pop;

   assign i_ready = r_n & (count != FULL);
   assign q_valid = r_n & (count != '0);
   assign push    = i_valid & i_ready;
   assign pop     = q_valid & q_ready;

   // The oldest entry sits at count-1; on push+pop the shift brings the
   // next-oldest into that same slot, so count stays put.
   always_ff @(posedge clk) begin
      if (!r_n) begin
         count <= '0;
      end else if (push && !pop) begin
         count <= count + 1'b1;
      end else if (pop && !push) begin
         count <= count - 1'b1;
      end
   end

   assign idx = (count == '0) ? '0 : (count - 1'b1);

   shreg_tap #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_tap (
      .clk  (clk),
      .en   (push),
      .din  (i_data),
      .idx  (idx),
      .dout (q_data)
   );

`ifdef SHREG_FIFO_LEVEL_EN
   assign level = count;
`endif

endmodule

// File: tb/tb_shreg_fifo.sv
// Randomised scoreboard bench for shreg_fifo: accepted writes are queued by
// the stimulus side and a negedge monitor checks handshakes and read data.
module tb_shreg_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 130;
   localparam int AW    = 8;

   logic             clk = 1'b0;
   logic             r_n;
   logic [WIDTH-1:0] i_data;
   logic             i_valid;
   logic             i_ready;
   logic [WIDTH-1:0] q_data;
   logic             q_valid;
   logic             q_ready;
`ifdef SHREG_FIFO_LEVEL_EN
   logic [AW-1:0]    level;
`endif

   logic [WIDTH-1:0] expq[$];
   int               checks = 0;
   int               errors = 0;

   shreg_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) dut (
      .clk     (clk),
      .r_n     (r_n),
      .i_data  (i_data),
      .i_valid (i_valid),
      .i_ready (i_ready),
      .q_data  (q_data),
      .q_valid (q_valid),
      .q_ready (q_ready)
`ifdef SHREG_FIFO_LEVEL_EN
      ,
      .level   (level)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Called right after a rising edge: drives inputs for the next edge and,
   // once that edge has happened, records what the FIFO must now hold.
   task automatic applyStimulus(input logic rn, input logic iv,
                                input logic [WIDTH-1:0] d, input logic qr);
      logic accepted;
      #1;
      r_n     = rn;
      i_valid = iv;
      i_data  = d;
      q_ready = qr;
      accepted = rn && iv && (expq.size() < DEPTH);
      @(posedge clk);
      if (!rn) begin
         expq.delete();
      end else if (accepted) begin
         expq.push_back(d);
      end
   endtask

   // The front of the queue is what the FIFO must present; it leaves the
   // queue when the reader takes it at the upcoming edge.
   always @(negedge clk) begin
      logic expValid;
      expValid = r_n && (expq.size() > 0);
      checkOutput("i_ready", {31'b0, i_ready}, {31'b0, r_n && (expq.size() < DEPTH)});
      checkOutput("q_valid", {31'b0, q_valid}, {31'b0, expValid});
`ifdef SHREG_FIFO_LEVEL_EN
      checkOutput("level", {24'b0, level}, expq.size());
`endif
      if (expValid) begin
         checkOutput("q_data", {24'b0, q_data}, {24'b0, expq[0]});
         if (q_ready) void'(expq.pop_front());
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      r_n     = 1'b0;
      i_valid = 1'b0;
      i_data  = '0;
      q_ready = 1'b0;
      @(posedge clk);

      // reset then idle
      applyStimulus(1'b0, 1'b1, 8'h55, 1'b1);
      applyStimulus(1'b0, 1'b1, 8'hAA, 1'b1);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);

      // single word, then one pop pulse
      applyStimulus(1'b1, 1'b1, 8'h01, 1'b0);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);

      // fill to DEPTH plus one refused write, then drain
      for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b1, 1'b1, 8'(i & 1), 1'b0);
      applyStimulus(1'b1, 1'b1, 8'hFF, 1'b0);
      for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);

      // full with simultaneous write and read, then drain
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b1, 8'($urandom), 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 8'($urandom), 1'b1);
      for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);

      // sustained streaming
      for (int i = 0; i < 500; i++) applyStimulus(1'b1, 1'b1, 8'($urandom), 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);

      // reset mid-stream at occupancy 40, then a fresh word
      for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b1, 8'($urandom), 1'b0);
      applyStimulus(1'b0, 1'b1, 8'h77, 1'b0);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
      applyStimulus(1'b1, 1'b1, 8'h01, 1'b0);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);

      // random traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 59) != 0), 1'($urandom_range(0, 3) != 0),
                       8'($urandom), 1'($urandom_range(0, 2) == 0));
      end
      for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);

      @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
